// File: rtl/oaat_hash_pkg.sv
// rtl/oaat_hash_pkg.sv - shared constants and round/finalisation math for the OAAT hash pipeline
package oaat_hash_pkg;

  localparam int HASH_W = 32;

  // Shift amounts are frozen: existing lookup tables were built with them.
  localparam int unsigned RND_SHL   = 11;
  localparam int unsigned RND_SHR   = 5;
  localparam int unsigned FIN_SHL_A = 4;
  localparam int unsigned FIN_SHR   = 10;
  localparam int unsigned FIN_SHL_B = 14;

  function automatic logic [HASH_W-1:0] oaat_round(input logic [HASH_W-1:0] h,
                                                   input logic [7:0]        b);
    logic [HASH_W-1:0] a;
    logic [HASH_W-1:0] c;
    a = h + {24'd0, b};
    c = a + (a << RND_SHL);
    return c ^ (c >> RND_SHR);
  endfunction

  function automatic logic [HASH_W-1:0] oaat_final(input logic [HASH_W-1:0] h);
    logic [HASH_W-1:0] f0;
    logic [HASH_W-1:0] f1;
    f0 = h + (h << FIN_SHL_A);
    f1 = f0 ^ (f0 >> FIN_SHR);
    return f1 + (f1 << FIN_SHL_B);
  endfunction

endpackage

// File: rtl/oaat_hash_pipe_if.sv
// rtl/oaat_hash_pipe_if.sv - key-in / hash-out handshake bundle for oaat_hash_pipe
interface oaat_hash_pipe_if
  import oaat_hash_pkg::*;
#(
  parameter int KEY_BYTES = 6,
  parameter int TAG_W     = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [8*KEY_BYTES-1:0] in_key;
  logic [HASH_W-1:0]      in_seed;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [HASH_W-1:0]      out_hash;
  logic [TAG_W-1:0]       out_tag;

  modport master (
    output in_valid, in_key, in_seed, in_tag, out_ready,
    input  in_ready, out_valid, out_hash, out_tag
  );

  modport slave (
    input  in_valid, in_key, in_seed, in_tag, out_ready,
    output in_ready, out_valid, out_hash, out_tag
  );
endinterface

// File: rtl/oaat_hash_stage.sv
// rtl/oaat_hash_stage.sv - one pipeline stage: folds BYTES_PER_STAGE key bytes and registers the rest
module oaat_hash_stage
  import oaat_hash_pkg::*;
#(
  parameter int BYTES_PER_STAGE = 1,
  parameter int REM_BYTES       = 6,
  parameter int TAG_W           = 8,
  localparam int OUT_KW = (REM_BYTES > BYTES_PER_STAGE) ? 8*(REM_BYTES-BYTES_PER_STAGE) : 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [HASH_W-1:0]      in_hash,
  input  logic [8*REM_BYTES-1:0] in_key,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  output logic [HASH_W-1:0]      out_hash,
  output logic [OUT_KW-1:0]      out_key,
  output logic [TAG_W-1:0]       out_tag
);

  logic [HASH_W-1:0] hash_next;

  // Most significant remaining byte is consumed first.
  always_comb begin
    hash_next = in_hash;
    for (int i = 0; i < BYTES_PER_STAGE; i++) begin
      hash_next = oaat_round(hash_next, in_key[8*(REM_BYTES-i)-1 -: 8]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_hash  <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_hash  <= hash_next;
      out_tag   <= in_tag;
    end
  end

  if (REM_BYTES > BYTES_PER_STAGE) begin : g_key
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_key <= '0;
      end else if (en) begin
        out_key <= in_key[OUT_KW-1:0];
      end
    end
  end else begin : g_no_key
    assign out_key = '0;
  end

endmodule

// File: rtl/oaat_hash_pipe.sv
// rtl/oaat_hash_pipe.sv - fully pipelined one-at-a-time hash with seed, sideband tag and backpressure
module oaat_hash_pipe
  import oaat_hash_pkg::*;
#(
  parameter int KEY_BYTES       = 6,
  parameter int BYTES_PER_STAGE = 1,
  parameter int TAG_W           = 8
) (
  input  logic            clk,
  input  logic            reset,
  oaat_hash_pipe_if.slave bus
);

  localparam int NSTAGE = KEY_BYTES / BYTES_PER_STAGE;
  localparam int KEY_W  = 8 * KEY_BYTES;

  if (KEY_BYTES < 1 || KEY_BYTES > 16) begin : g_bad_key_bytes
    $error("oaat_hash_pipe: KEY_BYTES must be 1..16");
  end
  if (BYTES_PER_STAGE < 1 || (KEY_BYTES % BYTES_PER_STAGE) != 0) begin : g_bad_bps
    $error("oaat_hash_pipe: KEY_BYTES must be a multiple of BYTES_PER_STAGE");
  end

  logic              en;
  logic [NSTAGE:0]   v_chain;
  logic [HASH_W-1:0] h_chain [NSTAGE+1];
  logic [KEY_W-1:0]  k_chain [NSTAGE+1];
  logic [TAG_W-1:0]  t_chain [NSTAGE+1];

  logic              out_valid_q;
  logic [HASH_W-1:0] out_hash_q;
  logic [TAG_W-1:0]  out_tag_q;

  // Whole pipe moves in lockstep; bubbles advance too, so only a held result stalls it.
  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  assign v_chain[0] = bus.in_valid;
  assign h_chain[0] = bus.in_seed;
  assign k_chain[0] = bus.in_key;
  assign t_chain[0] = bus.in_tag;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int REM    = KEY_BYTES - k*BYTES_PER_STAGE;
    localparam int OUT_KW = (REM > BYTES_PER_STAGE) ? 8*(REM-BYTES_PER_STAGE) : 8;

    logic [OUT_KW-1:0] key_q;

    oaat_hash_stage #(
      .BYTES_PER_STAGE (BYTES_PER_STAGE),
      .REM_BYTES       (REM),
      .TAG_W           (TAG_W)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .in_valid  (v_chain[k]),
      .in_hash   (h_chain[k]),
      .in_key    (k_chain[k][8*REM-1:0]),
      .in_tag    (t_chain[k]),
      .out_valid (v_chain[k+1]),
      .out_hash  (h_chain[k+1]),
      .out_key   (key_q),
      .out_tag   (t_chain[k+1])
    );

    assign k_chain[k+1] = KEY_W'(key_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_hash_q  <= '0;
      out_tag_q   <= '0;
    end else if (en) begin
      out_valid_q <= v_chain[NSTAGE];
      out_hash_q  <= oaat_final(h_chain[NSTAGE]);
      out_tag_q   <= t_chain[NSTAGE];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_hash  = out_hash_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_oaat_hash_pipe.sv
// tb/tb_oaat_hash_pipe.sv - randomized self-checking bench for oaat_hash_pipe against a byte-loop model
`timescale 1ns/1ps
module tb_oaat_hash_pipe;

  localparam int KB  = 6;
  localparam int TW  = 8;
  localparam int NSW = 7;
  localparam logic [NSW-1:0][7:0] SW_KB  = {8'd12, 8'd12, 8'd12, 8'd4, 8'd4, 8'd4, 8'd1};
  localparam logic [NSW-1:0][7:0] SW_BPS = {8'd4,  8'd2,  8'd1,  8'd4, 8'd2, 8'd1, 8'd1};

  typedef struct packed {
    logic [31:0]   h;
    logic [TW-1:0] t;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  oaat_hash_pipe_if #(.KEY_BYTES(KB), .TAG_W(TW)) bus ();

  oaat_hash_pipe #(.KEY_BYTES(KB), .BYTES_PER_STAGE(1), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  logic           sw_in_valid;
  logic [95:0]    sw_key;
  logic [31:0]    sw_seed;
  logic [TW-1:0]  sw_tag;
  logic [NSW-1:0] sw_valid;
  logic [NSW-1:0] sw_ready;
  logic [31:0]    sw_hash  [NSW];
  logic [TW-1:0]  sw_tag_o [NSW];

  for (genvar g = 0; g < NSW; g++) begin : g_sw
    localparam int GKB  = int'(SW_KB[g]);
    localparam int GBPS = int'(SW_BPS[g]);
    oaat_hash_pipe_if #(.KEY_BYTES(GKB), .TAG_W(TW)) sif ();
    assign sif.in_valid  = sw_in_valid;
    assign sif.in_key    = sw_key[8*GKB-1:0];
    assign sif.in_seed   = sw_seed;
    assign sif.in_tag    = sw_tag;
    assign sif.out_ready = 1'b1;
    oaat_hash_pipe #(.KEY_BYTES(GKB), .BYTES_PER_STAGE(GBPS), .TAG_W(TW)) u_dut (
      .clk   (clk),
      .reset (rst),
      .bus   (sif)
    );
    assign sw_valid[g] = sif.out_valid;
    assign sw_ready[g] = sif.in_ready;
    assign sw_hash[g]  = sif.out_hash;
    assign sw_tag_o[g] = sif.out_tag;
  end

  // Reference: hash the low nb bytes of key, most significant first, then finalise.
  function automatic logic [31:0] ref_hash(input logic [127:0] key, input int nb,
                                           input logic [31:0] seed);
    logic [31:0] h;
    h = seed;
    for (int i = nb - 1; i >= 0; i--) begin
      h = h + 32'(key[8*i +: 8]);
      h = h + (h << 11);
      h = h ^ (h >> 5);
    end
    h = h + (h << 4);
    h = h ^ (h >> 10);
    h = h + (h << 14);
    return h;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    nvec++; if (bus.out_hash !== 32'h0) begin nerr++; $display("FAIL reset_out_hash got %h want 0", bus.out_hash); end
    nvec++; if (bus.out_tag !== 8'h0) begin nerr++; $display("FAIL reset_out_tag got %h want 0", bus.out_tag); end
    nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed(input string name, input logic [47:0] key,
                               input logic [31:0] want, input logic [7:0] tag);
    int lat;
    bit seen;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_key = key; bus.in_seed = 32'h0; bus.in_tag = tag; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 20) begin
      if (bus.out_valid === 1'b1) seen = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    nvec++; if (!seen || lat != 7) begin nerr++; $display("FAIL %s_latency got %0d want 7 (seen=%0b)", name, lat, seen); end
    nvec++; if (bus.out_hash !== want) begin nerr++; $display("FAIL %s_hash got %h want %h", name, bus.out_hash, want); end
    nvec++; if (bus.out_tag !== tag) begin nerr++; $display("FAIL %s_tag got %h want %h", name, bus.out_tag, tag); end
    @(negedge clk);
  endtask

  task automatic test_single_byte_narrow();
    @(negedge clk);
    sw_in_valid = 1'b1; sw_key = 96'h1; sw_seed = 32'h0; sw_tag = 8'h3C;
    @(negedge clk);
    sw_in_valid = 1'b0;
    nvec++; if (sw_valid[0] !== 1'b0) begin nerr++; $display("FAIL kb1_early_valid got %b want 0", sw_valid[0]); end
    @(negedge clk);
    nvec++; if (sw_valid[0] !== 1'b1) begin nerr++; $display("FAIL kb1_valid got %b want 1", sw_valid[0]); end
    nvec++; if (sw_hash[0] !== 32'h231D0C72) begin nerr++; $display("FAIL kb1_hash got %h want 231d0c72", sw_hash[0]); end
    nvec++; if (sw_tag_o[0] !== 8'h3C) begin nerr++; $display("FAIL kb1_tag got %h want 3c", sw_tag_o[0]); end
    repeat (16) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [47:0] keys [32];
    logic [31:0] seeds [32];
    bit          exp_v;
    for (int i = 0; i < 32; i++) begin
      keys[i]  = 48'({$urandom(), $urandom()});
      seeds[i] = $urandom();
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 42; j++) begin
      @(negedge clk);
      exp_v = (j >= 7 && j < 39);
      nvec++; if (bus.out_valid !== exp_v) begin nerr++; $display("FAIL b2b_valid cycle %0d got %b want %b", j, bus.out_valid, exp_v); end
      if (exp_v && bus.out_valid === 1'b1) begin
        nvec++; if (bus.out_tag !== 8'(j-7)) begin nerr++; $display("FAIL b2b_tag cycle %0d got %0d want %0d", j, bus.out_tag, j-7); end
        nvec++; if (bus.out_hash !== ref_hash(128'(keys[j-7]), KB, seeds[j-7])) begin
          nerr++; $display("FAIL b2b_hash cycle %0d got %h want %h", j, bus.out_hash, ref_hash(128'(keys[j-7]), KB, seeds[j-7]));
        end
      end
      if (j < 32) begin
        bus.in_valid = 1'b1; bus.in_key = keys[j]; bus.in_seed = seeds[j]; bus.in_tag = 8'(j);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 60;
    exp_t        q[$];
    exp_t        e;
    int          sent, got;
    bit          prev_stall;
    logic [31:0] prev_h;
    logic [7:0]  prev_t;
    sent = 0; got = 0; prev_stall = 1'b0; prev_h = '0; prev_t = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        nvec++;
        if (bus.out_valid !== 1'b1 || bus.out_hash !== prev_h || bus.out_tag !== prev_t) begin
          nerr++; $display("FAIL bp_stall_stable cycle %0d got v=%b h=%h t=%h want v=1 h=%h t=%h",
                           c, bus.out_valid, bus.out_hash, bus.out_tag, prev_h, prev_t);
        end
      end
      bus.in_valid  = (sent < N) && ($urandom_range(0, 9) < 7);
      bus.in_key    = 48'({$urandom(), $urandom()});
      bus.in_seed   = $urandom();
      bus.in_tag    = 8'(sent);
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      nvec++; if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        nerr++; $display("FAIL bp_in_ready cycle %0d got %b want %b", c, bus.in_ready, !bus.out_valid || bus.out_ready);
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back('{h: ref_hash(128'(bus.in_key), KB, bus.in_seed), t: 8'(sent)});
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++; $display("FAIL bp_duplicate cycle %0d got tag %0d want no result", c, bus.out_tag);
        end else begin
          e = q.pop_front();
          got++;
          if (bus.out_hash !== e.h || bus.out_tag !== e.t) begin
            nerr++; $display("FAIL bp_result cycle %0d got h=%h t=%0d want h=%h t=%0d", c, bus.out_hash, bus.out_tag, e.h, e.t);
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_h = bus.out_hash;
      prev_t = bus.out_tag;
    end
    bus.in_valid = 1'b0;
    nvec++; if (got != N || q.size() != 0) begin
      nerr++; $display("FAIL bp_count got %0d results (%0d pending) want %0d", got, q.size(), N);
    end
  endtask

  task automatic test_reset_midflight();
    int          n;
    int          lat;
    bit          seen;
    logic [47:0] k;
    logic [31:0] s;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_key = 48'({$urandom(), $urandom()}); bus.in_seed = $urandom(); bus.in_tag = 8'(j);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    nvec++; if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL rst_mid_pre_valid got %b want 1", bus.out_valid); end
    #2 rst = 1'b1;
    #1;
    nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL rst_mid_valid got %b want 0", bus.out_valid); end
    nvec++; if (bus.out_hash !== 32'h0) begin nerr++; $display("FAIL rst_mid_hash got %h want 0", bus.out_hash); end
    nvec++; if (bus.out_tag !== 8'h0) begin nerr++; $display("FAIL rst_mid_tag got %h want 0", bus.out_tag); end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL rst_mid_stale cycle %0d got %b want 0", j, bus.out_valid); end
    end
    k = 48'({$urandom(), $urandom()});
    s = $urandom();
    bus.in_valid = 1'b1; bus.in_key = k; bus.in_seed = s; bus.in_tag = 8'hE7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 20) begin
      if (bus.out_valid === 1'b1) seen = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    nvec++; if (!seen || lat != 7) begin nerr++; $display("FAIL rst_mid_after_latency got %0d want 7", lat); end
    nvec++; if (bus.out_hash !== ref_hash(128'(k), KB, s) || bus.out_tag !== 8'hE7) begin
      nerr++; $display("FAIL rst_mid_after_result got h=%h t=%h want h=%h t=e7", bus.out_hash, bus.out_tag, ref_hash(128'(k), KB, s));
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [95:0] keys [20];
    int          lat;
    bit          exp_v;
    for (int i = 0; i < 20; i++) keys[i] = {$urandom(), $urandom(), $urandom()};
    sw_seed = 32'hDEADBEEF;
    for (int j = 0; j < 36; j++) begin
      @(negedge clk);
      for (int g = 0; g < NSW; g++) begin
        lat = int'(SW_KB[g]) / int'(SW_BPS[g]) + 1;
        exp_v = (j >= lat && j < lat + 20);
        nvec++; if (sw_ready[g] !== 1'b1) begin nerr++; $display("FAIL sweep%0d_in_ready got %b want 1", g, sw_ready[g]); end
        nvec++; if (sw_valid[g] !== exp_v) begin nerr++; $display("FAIL sweep%0d_valid cycle %0d got %b want %b", g, j, sw_valid[g], exp_v); end
        if (exp_v && sw_valid[g] === 1'b1) begin
          nvec++; if (sw_hash[g] !== ref_hash(128'(keys[j-lat]), int'(SW_KB[g]), 32'hDEADBEEF) || sw_tag_o[g] !== 8'(j-lat)) begin
            nerr++; $display("FAIL sweep%0d_result cycle %0d got h=%h t=%0d want h=%h t=%0d", g, j, sw_hash[g], sw_tag_o[g],
                             ref_hash(128'(keys[j-lat]), int'(SW_KB[g]), 32'hDEADBEEF), j-lat);
          end
        end
      end
      if (j < 20) begin
        sw_in_valid = 1'b1; sw_key = keys[j]; sw_tag = 8'(j);
      end else begin
        sw_in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_key = '0; bus.in_seed = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    sw_in_valid = 1'b0; sw_key = '0; sw_seed = '0; sw_tag = '0;
    test_reset();
    test_directed("zero_key", 48'h0, 32'h00000000, 8'hA5);
    test_directed("single_byte", 48'h1, 32'h231D0C72, 8'h5A);
    test_single_byte_narrow();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
